angle_pid_controller: RTL

ANGLE_PID_CONTROLLER -- requirements
Module: angle_pid_controller

---
 rtl/angle_pid_controller_if.sv | 21 ++
 rtl/angle_pid_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/angle_pid_controller_if.sv
// rtl/angle_pid_controller_if.sv - per-channel sensor/controller signal bundle
interface angle_pid_controller_if #(
  parameter int NUMBER_OF_SENSORS = 1
);
  logic [NUMBER_OF_SENSORS-1:0]    cycle;
  logic [32*NUMBER_OF_SENSORS-1:0] angle_absolute;
  logic [32*NUMBER_OF_SENSORS-1:0] setpoint;
  logic [NUMBER_OF_SENSORS-1:0]    enable;
  logic [16*NUMBER_OF_SENSORS-1:0] pid_out;
  logic [NUMBER_OF_SENSORS-1:0]    done;

  modport master (
    output cycle, angle_absolute, setpoint, enable,
    input  pid_out, done
  );

  modport slave (
    input  cycle, angle_absolute, setpoint, enable,
    output pid_out, done
  );
endinterface

// File: rtl/angle_pid_controller.sv
// rtl/angle_pid_controller.sv - time-shared multi-channel PID angle controller
module angle_pid_controller #(
  parameter int NUMBER_OF_SENSORS = 1,
  parameter int SHIFT = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  angle_pid_controller_if.slave     bus,
  input  logic signed [15:0]        Kp,
  input  logic signed [15:0]        Ki,
  input  logic signed [15:0]        Kd,
  input  logic [14:0]               integral_limit,
  input  logic [14:0]               output_limit,
  output logic                      busy
);
  localparam int N  = NUMBER_OF_SENSORS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, CLAMP, WRITE} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        pending_q, pending_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic                abort_q;
  logic [N-1:0]        done_q;
  logic signed [15:0]  integ_q    [N];
  logic signed [15:0]  err_prev_q [N];
  logic signed [15:0]  pid_q      [N];
  logic signed [15:0]  err_q, integ_w_q, deriv_q, clamp_q;
  logic signed [31:0]  p_q, i_q, d_q;
  logic signed [33:0]  sum_q;

  logic                sel_en;
  logic signed [31:0]  sp_c, ang_c;
  logic signed [32:0]  err_wide;
  logic signed [16:0]  deriv_wide;
  logic signed [17:0]  integ_wide, ilim, ilim_n;
  logic signed [15:0]  err_c, deriv_c, integ_c, clamp_c;
  logic signed [33:0]  sum_c, olim, olim_n;

  assign sel_en = bus.enable[chan_q];

  always_comb begin
    sp_c       = bus.setpoint[32*chan_q +: 32];
    ang_c      = bus.angle_absolute[32*chan_q +: 32];
    err_wide   = {sp_c[31], sp_c} - {ang_c[31], ang_c};
    if (err_wide > 33'sd32767)       err_c = 16'sh7fff;
    else if (err_wide < -33'sd32768) err_c = 16'sh8000;
    else                             err_c = err_wide[15:0];

    deriv_wide = {err_c[15], err_c} - {err_prev_q[chan_q][15], err_prev_q[chan_q]};
    if (deriv_wide > 17'sd32767)       deriv_c = 16'sh7fff;
    else if (deriv_wide < -17'sd32768) deriv_c = 16'sh8000;
    else                               deriv_c = deriv_wide[15:0];

    integ_wide = {{2{integ_q[chan_q][15]}}, integ_q[chan_q]} + {{2{err_c[15]}}, err_c};
    ilim       = {3'b000, integral_limit};
    ilim_n     = -ilim;
    if (integ_wide > ilim)        integ_c = ilim[15:0];
    else if (integ_wide < ilim_n) integ_c = ilim_n[15:0];
    else                          integ_c = integ_wide[15:0];

    sum_c  = {{2{p_q[31]}}, p_q} + {{2{i_q[31]}}, i_q} + {{2{d_q[31]}}, d_q};
    olim   = {19'b0, output_limit};
    olim_n = -olim;
    if (sum_q > olim)        clamp_c = olim[15:0];
    else if (sum_q < olim_n) clamp_c = olim_n[15:0];
    else                     clamp_c = sum_q[15:0];
  end

  // A new pulse wins over the IDLE-side clear so a mid-pass pulse reruns the channel.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    pending_d = pending_q;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (pending_q[k]) chan_d = CW'(k);
          end
          pending_d[chan_d] = 1'b0;
          state_d           = ERR;
        end
      end
      ERR:     state_d = MUL;
      MUL:     state_d = SUM;
      SUM:     state_d = CLAMP;
      CLAMP:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = (pending_d | bus.cycle) & bus.enable;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      chan_q    <= '0;
      abort_q   <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      integ_w_q <= '0;
      deriv_q   <= '0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      sum_q     <= '0;
      clamp_q   <= '0;
      for (int k = 0; k < N; k++) begin
        integ_q[k]    <= '0;
        err_prev_q[k] <= '0;
        pid_q[k]      <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      chan_q    <= chan_d;
      done_q    <= '0;
      for (int k = 0; k < N; k++) begin
        if (!bus.enable[k]) begin
          integ_q[k]    <= '0;
          err_prev_q[k] <= '0;
          pid_q[k]      <= '0;
        end
      end
      case (state_q)
        IDLE: abort_q <= 1'b0;
        ERR: begin
          err_q     <= err_c;
          deriv_q   <= deriv_c;
          integ_w_q <= integ_c;
          if (sel_en) integ_q[chan_q] <= integ_c;
        end
        MUL: begin
          p_q <= 32'(Kp) * 32'(err_q);
          i_q <= 32'(Ki) * 32'(integ_w_q);
          d_q <= 32'(Kd) * 32'(deriv_q);
        end
        SUM:   sum_q   <= sum_c >>> SHIFT;
        CLAMP: clamp_q <= clamp_c;
        WRITE: begin
          if (sel_en && !abort_q) begin
            pid_q[chan_q]      <= clamp_q;
            err_prev_q[chan_q] <= err_q;
            done_q[chan_q]     <= 1'b1;
          end
        end
        default: ;
      endcase
      // Any dip of enable during a pass discards it, even if enable returns before WRITE.
      if (state_q != IDLE && !sel_en) abort_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.pid_out[16*g +: 16] = pid_q[g];
  end
  assign bus.done = done_q;
endmodule
